// File: rtl/alu_arbiter.sv
// Two-port round-robin / fixed-priority arbiter in front of a shared 32-bit ALU.
// Each accepted op takes IDLE -> EXEC -> RESP, and the response is tagged with the requester ID.
module alu_arbiter #(
    parameter int FIX_PRIO = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [2:0]       req0_f,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [2:0]       req1_f,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2:0]       op_f_q, op_f_d;
    logic             op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic             is_sub, add_ovf, f_legal;
    logic [31:0]      b_eff, alu_res;
    logic [32:0]      sum;
    logic             alu_v, alu_c;
    logic             grant_id;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // SUB and SLT share the adder as a + ~b + 1; carry is then "no borrow".
    always_comb begin
        is_sub  = (op_f_q == 3'b001) || (op_f_q == 3'b101);
        b_eff   = is_sub ? ~op_b_q : op_b_q;
        sum     = {1'b0, op_a_q} + {1'b0, b_eff} + {32'd0, is_sub};
        add_ovf = (op_a_q[31] == b_eff[31]) && (sum[31] != op_a_q[31]);
        alu_res = 32'd0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        f_legal = 1'b1;
        case (op_f_q)
            3'b000, 3'b001: begin
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = add_ovf;
            end
            3'b010:  alu_res = op_a_q & op_b_q;
            3'b011:  alu_res = op_a_q | op_b_q;
            3'b101:  alu_res = {31'd0, sum[31] ^ add_ovf};
            default: f_legal = 1'b0;
        endcase
    end

    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id = (FIX_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            grant_id = ~req0_valid;
        end
        req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant_id;
        req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant_id;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_f_d       = op_f_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    op_a_d       = grant_id ? req1_a : req0_a;
                    op_b_d       = grant_id ? req1_b : req0_b;
                    op_f_d       = grant_id ? req1_f : req0_f;
                    op_id_d      = grant_id;
                    last_grant_d = grant_id;
                    if (grant_id) begin
                        if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_ONE;
                    end else begin
                        if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_ONE;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = op_id_q;
                rsp_err_d    = !f_legal;
                rsp_result_d = f_legal ? alu_res : 32'd0;
                rsp_flags_d  = f_legal ? {alu_res[31], alu_v, alu_c, (alu_res == 32'd0)} : 4'd0;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            op_f_q       <= 3'd0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_flags_q  <= 4'd0;
            rsp_err_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_f_q       <= op_f_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant rule, arithmetic ALU reference, saturating counts).
module tb_alu_arbiter;
    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic clk, rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_f, req1_f;
    logic rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [CW-1:0] cnt0, cnt1;

    logic f_rst_n, f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
    logic f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_err;
    logic [31:0] f_rsp_result;
    logic [3:0]  f_rsp_flags;
    logic [CW-1:0] f_cnt0, f_cnt1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter #(.FIX_PRIO(0), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err), .cnt0(cnt0), .cnt1(cnt1)
    );

    alu_arbiter #(.FIX_PRIO(1), .CNT_W(CW)) u_fix (
        .clk(clk), .rst_n(f_rst_n),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(32'd1), .req0_b(32'd2), .req0_f(3'b000),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(32'd9), .req1_b(32'd9), .req1_f(3'b000),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id), .rsp_result(f_rsp_result),
        .rsp_flags(f_rsp_flags), .rsp_err(f_rsp_err), .cnt0(f_cnt0), .cnt1(f_cnt1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Returns {err, N, V, C, Z, result} from plain integer arithmetic.
    function automatic logic [36:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        longint sa, sb, sr;
        longint unsigned ua, ub;
        logic [31:0] r;
        logic v, c;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sr = 0;
        v = 1'b0;
        c = 1'b0;
        case (f)
            3'b000: begin
                sr = sa + sb; r = a + b;
                v = (sr != longint'($signed(r)));
                c = ((ua + ub) >> 32) != 0;
            end
            3'b001: begin
                sr = sa - sb; r = a - b;
                v = (sr != longint'($signed(r)));
                c = (ua >= ub);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b101: r = (sa < sb) ? 32'd1 : 32'd0;
            default: return {1'b1, 4'b0000, 32'd0};
        endcase
        return {1'b0, r[31], v, c, (r == 32'd0), r};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference model state
    bit m_last, busy, mon_en, prev_valid, prev_ready, acc0, acc1, pid, e0, e1, fix_done;
    logic [CW-1:0] m_cnt0, m_cnt1;
    logic [37:0] exp_q[$];
    logic [37:0] snap, cur, e;
    logic grant_log[$];
    int obs = 0, acc_obs = 0, hs_obs = 0, acc1_obs = 0;

    always begin
        @(negedge clk);
        #2;
        if (mon_en) begin
            obs++;
            check("cnt0", cnt0, m_cnt0);
            check("cnt1", cnt1, m_cnt1);
            if (req0_valid && req1_valid) pid = m_last ? 1'b0 : 1'b1;
            else pid = req1_valid;
            e0 = !busy && (req0_valid || req1_valid) && !pid;
            e1 = !busy && (req0_valid || req1_valid) && pid;
            check("req0_ready", req0_ready, e0);
            check("req1_ready", req1_ready, e1);
            if (!busy) check("rsp_valid_idle", rsp_valid, 1'b0);
            cur = {rsp_id, rsp_err, rsp_flags, rsp_result};
            if (rsp_valid) begin
                if (!prev_valid) check("latency", obs - acc_obs, 2);
                else if (!prev_ready) check("rsp_stable", cur, snap);
                snap = cur;
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", rsp_id, e[37]);
                        check("rsp_err", rsp_err, e[36]);
                        check("rsp_flags", rsp_flags, e[35:32]);
                        check("rsp_result", rsp_result, e[31:0]);
                    end
                    busy = 1'b0;
                    hs_obs = obs;
                end
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (acc0 || acc1) begin
                exp_q.push_back({pid, pid ? ref_alu(req1_a, req1_b, req1_f) : ref_alu(req0_a, req0_b, req0_f)});
                m_last = pid;
                if (pid) begin
                    if (m_cnt1 != CMAX) m_cnt1 = m_cnt1 + 1'b1;
                    acc1_obs = obs;
                end else if (m_cnt0 != CMAX) begin
                    m_cnt0 = m_cnt0 + 1'b1;
                end
                grant_log.push_back(pid);
                busy = 1'b1;
                acc_obs = obs;
            end
        end
    end

    task automatic do_reset(input bit sync);
        mon_en = 1'b0;
        if (sync) @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_flags", rsp_flags, 4'd0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        m_last = 1'b1; busy = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
        prev_valid = 1'b0; prev_ready = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        exp_q.delete();
        grant_log.delete();
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic issue(input bit p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        @(negedge clk);
        if (!p) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f; end
        else begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (p ? acc1 : acc0) begin
                if (!p) req0_valid = 1'b0; else req1_valid = 1'b0;
                return;
            end
        end
        check("issue_timeout", 1, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check("idle_timeout", 1, 0);
    endtask

    task automatic both_run(input int n);
        int got;
        got = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = rand_op(); req0_b = rand_op(); req0_f = 3'($urandom_range(0, 7));
        req1_valid = 1'b1; req1_a = rand_op(); req1_b = rand_op(); req1_f = 3'($urandom_range(0, 7));
        for (int i = 0; i < 60 && got < n; i++) begin
            @(negedge clk);
            if (acc0) begin got++; req0_a = rand_op(); req0_b = rand_op(); req0_f = 3'($urandom_range(0, 7)); end
            if (acc1) begin got++; req1_a = rand_op(); req1_b = rand_op(); req1_f = 3'($urandom_range(0, 7)); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("both_count", got, n);
    endtask

    task automatic rand_phase(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (acc0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 9) < 4);
                req0_a = rand_op(); req0_b = rand_op(); req0_f = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 19) == 0) begin
                req0_valid = 1'b0;
            end
            if (acc1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 9) < 4);
                req1_a = rand_op(); req1_b = rand_op(); req1_f = 3'($urandom_range(0, 7));
            end else if ($urandom_range(0, 19) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
    endtask

    // Fixed-priority instance: both ports always valid, port 0 must win every time.
    initial begin
        int n, p1;
        fix_done = 1'b0;
        f_rst_n = 1'b0; f_req0_valid = 1'b0; f_req1_valid = 1'b0; f_rsp_ready = 1'b1;
        n = 0; p1 = 0;
        repeat (3) @(negedge clk);
        f_req0_valid = 1'b1;
        f_req1_valid = 1'b1;
        f_rst_n = 1'b1;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            #2;
            if (f_req1_ready) p1++;
            if (f_rsp_valid && f_rsp_ready) begin
                check("fix_rsp_id", f_rsp_id, 1'b0);
                check("fix_result", f_rsp_result, 32'd3);
                n++;
            end
        end
        f_req0_valid = 1'b0;
        f_req1_valid = 1'b0;
        @(negedge clk);
        #2;
        check("fix_rsp_count", n, 4);
        check("fix_port1_grants", p1, 0);
        check("fix_cnt0", f_cnt0, 4);
        check("fix_cnt1", f_cnt1, 0);
        fix_done = 1'b1;
    end

    initial begin
        int hs_then;
        mon_en = 1'b0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_f = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_f = '0;
        rsp_ready = 1'b1;
        do_reset(1'b1);

        issue(1'b0, 32'd7, 32'd5, 3'b000);
        wait_idle();
        check("add_result", rsp_result, 32'h0000_000C);
        check("add_flags", rsp_flags, 4'b0000);
        check("add_id", rsp_id, 1'b0);
        check("add_err", rsp_err, 1'b0);
        check("add_cnt0", cnt0, 1);

        issue(1'b1, 32'h8000_0000, 32'd1, 3'b001);
        wait_idle();
        check("sub_result", rsp_result, 32'h7FFF_FFFF);
        check("sub_flags", rsp_flags, 4'b0110);
        check("sub_id", rsp_id, 1'b1);

        issue(1'b0, 32'd3, 32'd4, 3'b110);
        wait_idle();
        check("ill_err", rsp_err, 1'b1);
        check("ill_result", rsp_result, 32'd0);
        check("ill_flags", rsp_flags, 4'd0);
        check("ill_cnt0", cnt0, 2);

        // Stall the response with port 1 waiting behind it.
        rsp_ready = 1'b0;
        issue(1'b0, 32'd100, 32'd1, 3'b011);
        req1_valid = 1'b1; req1_a = 32'd50; req1_b = 32'd60; req1_f = 3'b101;
        repeat (4) @(negedge clk);
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !acc1; i++) @(negedge clk);
        req1_valid = 1'b0;
        hs_then = hs_obs;
        wait_idle();
        check("stall_accept_gap", acc1_obs - hs_then, 1);

        do_reset(1'b1);
        both_run(4);
        wait_idle();
        check("rr_grants", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check("rr_grant_order", grant_log[i], i % 2);
        check("rr_cnt0", cnt0, 2);
        check("rr_cnt1", cnt1, 2);

        do_reset(1'b1);
        rsp_ready = 1'b1;
        issue(1'b0, 32'd1, 32'd1, 3'b000);
        check("exec_rsp_valid", rsp_valid, 1'b0);
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        issue(1'b1, 32'd10, 32'd3, 3'b001);
        wait_idle();
        check("post_rst_result", rsp_result, 32'd7);
        check("post_rst_cnt1", cnt1, 1);
        check("post_rst_cnt0", cnt0, 0);

        rand_phase(600);
        check("sat_cnt0", cnt0, CMAX);
        check("sat_cnt1", cnt1, CMAX);

        for (int i = 0; i < 200 && !fix_done; i++) @(negedge clk);
        check("fix_done", fix_done, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
